// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the streaming radix-3 butterfly.
// Twiddle constants are Q10 with COEF_FRAC fractional bits.
package fft_pkg;

   localparam int COEF_W    = 18;
   localparam int COEF_FRAC = 10;

   localparam logic signed [COEF_W-1:0] C_HALF = -18'sd512;
   localparam logic signed [COEF_W-1:0] C_SIN  = 18'sd887;

   typedef enum logic [1:0] {
      COLLECT,
      CALC,
      EMIT
   } state_t;

endpackage

// File: rtl/radix3_core.sv
// Combinational 3-point DFT: twiddle accumulation, round-half-up, optional
// right-shift scaling and saturation. Inverse mode swaps the y1/y2 outputs.
module radix3_core
   import fft_pkg::*;
#(
   parameter int WIDTH = 15,
   parameter int SHIFT = 0
) (
   input  logic [2:0][WIDTH-1:0] i_x_re,
   input  logic [2:0][WIDTH-1:0] i_x_im,
   input  logic                  i_inv,
   output logic [2:0][WIDTH-1:0] o_y_re,
   output logic [2:0][WIDTH-1:0] o_y_im,
   output logic [2:0]            o_sat
);

   localparam int AW = WIDTH + 13;
   localparam int RS = COEF_FRAC + SHIFT;

   localparam logic signed [AW-1:0] K_HALF = AW'(C_HALF);
   localparam logic signed [AW-1:0] K_SIN  = AW'(C_SIN);
   localparam logic signed [AW-1:0] RND    = AW'(1) <<< (RS - 1);
   localparam logic signed [AW-1:0] MAXV   = (AW'(1) <<< (WIDTH - 1)) - AW'(1);
   localparam logic signed [AW-1:0] MINV   = -(AW'(1) <<< (WIDTH - 1));

   // Returns {clipped, value}.
   function automatic logic [WIDTH:0] round_sat(input logic signed [AW-1:0] a);
      logic signed [AW-1:0] r;
      r = (a + RND) >>> RS;
      if (r > MAXV)
         round_sat = {1'b1, MAXV[WIDTH-1:0]};
      else if (r < MINV)
         round_sat = {1'b1, MINV[WIDTH-1:0]};
      else
         round_sat = {1'b0, r[WIDTH-1:0]};
   endfunction

   logic signed [AW-1:0] w_x0_re, w_x0_im, w_x1_re, w_x1_im, w_x2_re, w_x2_im;
   logic signed [AW-1:0] w_t_re, w_t_im, w_d_re, w_d_im;
   logic signed [AW-1:0] w_base_re, w_base_im, w_sd_re, w_sd_im;
   logic signed [AW-1:0] w_f1_re, w_f1_im, w_f2_re, w_f2_im;
   logic signed [AW-1:0] w_acc_re [3];
   logic signed [AW-1:0] w_acc_im [3];
   logic [2:0]           w_sat_re, w_sat_im;

   assign w_x0_re = AW'($signed(i_x_re[0]));
   assign w_x0_im = AW'($signed(i_x_im[0]));
   assign w_x1_re = AW'($signed(i_x_re[1]));
   assign w_x1_im = AW'($signed(i_x_im[1]));
   assign w_x2_re = AW'($signed(i_x_re[2]));
   assign w_x2_im = AW'($signed(i_x_im[2]));

   assign w_t_re = w_x1_re + w_x2_re;
   assign w_t_im = w_x1_im + w_x2_im;
   assign w_d_re = w_x1_re - w_x2_re;
   assign w_d_im = w_x1_im - w_x2_im;

   assign w_base_re = (w_x0_re <<< COEF_FRAC) + K_HALF * w_t_re;
   assign w_base_im = (w_x0_im <<< COEF_FRAC) + K_HALF * w_t_im;
   assign w_sd_re   = K_SIN * w_d_re;
   assign w_sd_im   = K_SIN * w_d_im;

   assign w_f1_re = w_base_re + w_sd_im;
   assign w_f1_im = w_base_im - w_sd_re;
   assign w_f2_re = w_base_re - w_sd_im;
   assign w_f2_im = w_base_im + w_sd_re;

   assign w_acc_re[0] = (w_x0_re + w_t_re) <<< COEF_FRAC;
   assign w_acc_im[0] = (w_x0_im + w_t_im) <<< COEF_FRAC;
   // The inverse transform uses the conjugate twiddle, which just exchanges y1 and y2.
   assign w_acc_re[1] = i_inv ? w_f2_re : w_f1_re;
   assign w_acc_im[1] = i_inv ? w_f2_im : w_f1_im;
   assign w_acc_re[2] = i_inv ? w_f1_re : w_f2_re;
   assign w_acc_im[2] = i_inv ? w_f1_im : w_f2_im;

   for (genvar k = 0; k < 3; k++) begin : g_out
      assign {w_sat_re[k], o_y_re[k]} = round_sat(w_acc_re[k]);
      assign {w_sat_im[k], o_y_im[k]} = round_sat(w_acc_im[k]);
   end

   assign o_sat = w_sat_re | w_sat_im;

endmodule

// File: rtl/radix3_bfly_stream.sv
// Streaming radix-3 butterfly: collects a triple over valid/ready, computes
// it in one cycle, then emits y0..y2 serially under backpressure.
module radix3_bfly_stream
   import fft_pkg::*;
#(
   parameter int WIDTH = 15,
   parameter int SHIFT = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_re,
   input  logic signed [WIDTH-1:0] in_im,
   input  logic                    in_inv,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_re,
   output logic signed [WIDTH-1:0] out_im,
   output logic [1:0]              out_idx,
   output logic                    out_last,
   output logic                    out_sat
);

   state_t                  r_state;
   logic [1:0]              r_cnt;
   logic                    r_inv;
   logic [2:0][WIDTH-1:0]   r_x_re, r_x_im, r_y_re, r_y_im;
   logic [2:0]              r_sat;
   logic                    r_out_valid, r_out_last, r_out_sat;
   logic [1:0]              r_out_idx;
   logic signed [WIDTH-1:0] r_out_re, r_out_im;

   logic [2:0][WIDTH-1:0]   w_y_re, w_y_im;
   logic [2:0]              w_sat;
   logic [1:0]              w_cnt_nxt;

   assign w_cnt_nxt = r_cnt + 2'd1;

   radix3_core #(
      .WIDTH (WIDTH),
      .SHIFT (SHIFT)
   ) u_core (
      .i_x_re (r_x_re),
      .i_x_im (r_x_im),
      .i_inv  (r_inv),
      .o_y_re (w_y_re),
      .o_y_im (w_y_im),
      .o_sat  (w_sat)
   );

   // Ready is forced low while reset is asserted, then follows the state directly.
   assign in_ready  = (r_state == COLLECT) && !rst;
   assign out_valid = r_out_valid;
   assign out_re    = r_out_re;
   assign out_im    = r_out_im;
   assign out_idx   = r_out_idx;
   assign out_last  = r_out_last;
   assign out_sat   = r_out_sat;

   // NOTE: sample and result slots are reset too, so a discarded partial triple
   // can never leak into a later result or onto the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= COLLECT;
         r_cnt       <= '0;
         r_inv       <= 1'b0;
         r_x_re      <= '0;
         r_x_im      <= '0;
         r_y_re      <= '0;
         r_y_im      <= '0;
         r_sat       <= '0;
         r_out_valid <= 1'b0;
         r_out_re    <= '0;
         r_out_im    <= '0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
         r_out_sat   <= 1'b0;
      end else begin
         case (r_state)
            COLLECT: begin
               if (in_valid) begin
                  r_x_re[r_cnt] <= in_re;
                  r_x_im[r_cnt] <= in_im;
                  if (r_cnt == 2'd0) r_inv <= in_inv;
                  if (r_cnt == 2'd2) begin
                     r_cnt   <= '0;
                     r_state <= CALC;
                  end else begin
                     r_cnt <= w_cnt_nxt;
                  end
               end
            end
            CALC: begin
               r_y_re      <= w_y_re;
               r_y_im      <= w_y_im;
               r_sat       <= w_sat;
               r_out_re    <= w_y_re[0];
               r_out_im    <= w_y_im[0];
               r_out_sat   <= w_sat[0];
               r_out_idx   <= 2'd0;
               r_out_last  <= 1'b0;
               r_out_valid <= 1'b1;
               r_cnt       <= '0;
               r_state     <= EMIT;
            end
            EMIT: begin
               if (out_ready) begin
                  if (r_cnt == 2'd2) begin
                     r_out_valid <= 1'b0;
                     r_cnt       <= '0;
                     r_state     <= COLLECT;
                  end else begin
                     r_cnt      <= w_cnt_nxt;
                     r_out_re   <= r_y_re[w_cnt_nxt];
                     r_out_im   <= r_y_im[w_cnt_nxt];
                     r_out_sat  <= r_sat[w_cnt_nxt];
                     r_out_idx  <= w_cnt_nxt;
                     r_out_last <= (w_cnt_nxt == 2'd2);
                  end
               end
            end
            default: r_state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_radix3_bfly_stream.sv
// Self-checking bench: directed and random triples against an arithmetic
// 3-point DFT reference, with stalls and a mid-triple reset.
module tb_radix3_bfly_stream;

   localparam int W = 15;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_inv, out_ready;
   logic signed [W-1:0] in_re, in_im;

   logic in_ready, out_valid, out_last, out_sat;
   logic signed [W-1:0] out_re, out_im;
   logic [1:0] out_idx;

   logic s1_in_ready, s1_out_valid, s1_out_last, s1_out_sat;
   logic signed [W-1:0] s1_out_re, s1_out_im;
   logic [1:0] s1_out_idx;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   radix3_bfly_stream #(.WIDTH(W), .SHIFT(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_re(in_re), .in_im(in_im), .in_inv(in_inv),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
      .out_last(out_last), .out_sat(out_sat)
   );

   radix3_bfly_stream #(.WIDTH(W), .SHIFT(1)) dut_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s1_in_ready),
      .in_re(in_re), .in_im(in_im), .in_inv(in_inv),
      .out_valid(s1_out_valid), .out_ready(out_ready),
      .out_re(s1_out_re), .out_im(s1_out_im), .out_idx(s1_out_idx),
      .out_last(s1_out_last), .out_sat(s1_out_sat)
   );

   task automatic check(input string tag, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", tag, act, exp);
      end
   endtask

   function automatic longint clip(input longint acc, input int sh, output bit sat);
      longint q;
      q   = (acc + (longint'(1) << (9 + sh))) >>> (10 + sh);
      sat = 1'b0;
      if (q > 16383)  begin q = 16383;  sat = 1'b1; end
      if (q < -16384) begin q = -16384; sat = 1'b1; end
      return q;
   endfunction

   // Plain-arithmetic 3-point DFT with Q10 twiddles.
   function automatic void model(input longint xr[3], input longint xi[3], input bit inv,
                                 input int sh, output longint yr[3], output longint yi[3],
                                 output bit ys[3]);
      longint ar[3], ai[3], tr, ti, dr, di;
      bit sr, si;
      tr = xr[1] + xr[2];  ti = xi[1] + xi[2];
      dr = xr[1] - xr[2];  di = xi[1] - xi[2];
      ar[0] = (xr[0] + tr) * 1024;
      ai[0] = (xi[0] + ti) * 1024;
      ar[1] = xr[0] * 1024 - 512 * tr + 887 * di;
      ai[1] = xi[0] * 1024 - 512 * ti - 887 * dr;
      ar[2] = xr[0] * 1024 - 512 * tr - 887 * di;
      ai[2] = xi[0] * 1024 - 512 * ti + 887 * dr;
      for (int k = 0; k < 3; k++) begin
         int m;
         m = (inv && k != 0) ? 3 - k : k;
         yr[k] = clip(ar[m], sh, sr);
         yi[k] = clip(ai[m], sh, si);
         ys[k] = sr | si;
      end
   endfunction

   task automatic run_triple(input string tag, input longint xr[3], input longint xi[3],
                             input bit inv0, input bit inv_rest,
                             input int stall_idx, input int stall_n);
      longint er[3], ei[3], sr1[3], si1[3];
      bit es[3], ss1[3];
      int k;
      model(xr, xi, inv0, 0, er, ei, es);
      model(xr, xi, inv0, 1, sr1, si1, ss1);
      out_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_re    = W'(xr[b]);
         in_im    = W'(xi[b]);
         in_inv   = (b == 0) ? inv0 : inv_rest;
         k = 0;
         while (!in_ready && k < 50) begin @(negedge clk); k++; end
         if (k == 50) begin check({tag, " in_timeout"}, 1, 0); in_valid = 1'b0; return; end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, " calc_valid"}, out_valid, 0);
      check({tag, " calc_ready"}, in_ready, 0);
      for (int o = 0; o < 3; o++) begin
         @(negedge clk);
         k = 0;
         while (!out_valid && k < 50) begin @(negedge clk); k++; end
         if (o == 0) check({tag, " latency"}, k, 0);
         if (k == 50) begin check({tag, " out_timeout"}, 1, 0); return; end
         check($sformatf("%s y%0d idx", tag, o), out_idx, o);
         check($sformatf("%s y%0d last", tag, o), out_last, (o == 2));
         check($sformatf("%s y%0d re", tag, o), out_re, er[o]);
         check($sformatf("%s y%0d im", tag, o), out_im, ei[o]);
         check($sformatf("%s y%0d sat", tag, o), out_sat, es[o]);
         check($sformatf("%s y%0d re_sh1", tag, o), s1_out_re, sr1[o]);
         check($sformatf("%s y%0d im_sh1", tag, o), s1_out_im, si1[o]);
         if (o == stall_idx) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               @(negedge clk);
               check($sformatf("%s stall%0d valid", tag, s), out_valid, 1);
               check($sformatf("%s stall%0d idx", tag, s), out_idx, o);
               check($sformatf("%s stall%0d re", tag, s), out_re, er[o]);
               check($sformatf("%s stall%0d im", tag, s), out_im, ei[o]);
               check($sformatf("%s stall%0d ready", tag, s), in_ready, 0);
            end
            out_ready = 1'b1;
         end
         @(posedge clk);
      end
      @(negedge clk);
      check({tag, " ready_back"}, in_ready, 1);
      check({tag, " valid_drop"}, out_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint xr[3], xi[3];
      rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b1;
      in_re = '0; in_im = '0;
      #12;
      check("rst in_ready", in_ready, 0);
      check("rst out_valid", out_valid, 0);
      check("rst out_re", out_re, 0);
      check("rst out_idx", out_idx, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel in_ready", in_ready, 1);

      xr = '{100, 0, 0};     xi = '{0, 0, 0};
      run_triple("impulse", xr, xi, 0, 0, -1, 0);
      xr = '{300, 300, 300}; xi = '{0, 0, 0};
      run_triple("dc", xr, xi, 0, 0, -1, 0);
      xr = '{0, 1000, 0};    xi = '{0, 0, 0};
      run_triple("twid_fwd", xr, xi, 0, 0, -1, 0);
      run_triple("twid_inv", xr, xi, 1, 0, -1, 0);
      run_triple("mode_toggle", xr, xi, 0, 1, -1, 0);
      xr = '{16000, 16000, 16000}; xi = '{0, 0, 0};
      run_triple("saturate", xr, xi, 0, 0, -1, 0);
      xr = '{-16384, -16384, -16384}; xi = '{16383, -16384, 200};
      run_triple("neg_sat", xr, xi, 1, 1, -1, 0);
      xr = '{1234, -567, 890}; xi = '{-42, 3000, -2500};
      run_triple("stall", xr, xi, 0, 0, 1, 5);

      // Reset mid-triple: two samples accepted, then discarded.
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         in_valid = 1'b1; in_re = 15'sd5000; in_im = -15'sd3000; in_inv = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst in_ready", in_ready, 0);
      check("mid_rst out_valid", out_valid, 0);
      check("mid_rst out_re", out_re, 0);
      check("mid_rst out_im", out_im, 0);
      check("mid_rst out_idx", out_idx, 0);
      check("mid_rst out_last", out_last, 0);
      check("mid_rst out_sat", out_sat, 0);
      @(negedge clk);
      rst = 1'b0;
      xr = '{100, 0, 0}; xi = '{0, 0, 0};
      run_triple("post_rst", xr, xi, 0, 0, -1, 0);

      for (int n = 0; n < 24; n++) begin
         for (int b = 0; b < 3; b++) begin
            if (n % 4 == 0) begin
               xr[b] = longint'($signed(W'($urandom)));
               xi[b] = longint'($signed(W'($urandom)));
            end else begin
               xr[b] = longint'($urandom_range(0, 8000)) - 4000;
               xi[b] = longint'($urandom_range(0, 8000)) - 4000;
            end
         end
         run_triple($sformatf("rnd%0d", n), xr, xi, 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/radix3_bfly_stream.md
# radix3_bfly_stream

- Streaming, parametrised radix-3 butterfly for the PUSCH FFT/IFFT datapath.
- Accepts complex samples serially over a valid/ready interface and collects one triple (x0, x1, x2).
- Computes the 3-point DFT, forward or inverse per triple, with rounding, optional right-shift scaling and saturation.
- Emits the triple (y0, y1, y2) serially with backpressure; it replaces the fixed, combinational 3-point butterfly in mixed-radix stages.

## Interface
Parameters:
- WIDTH, 15: signed sample width, re and im each.
- SHIFT, 0: output right-shift after the butterfly, range 0..2; 0 = unscaled.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_re, in_im  in  WIDTH  signed input sample.
- in_inv  in  1  0 = forward, 1 = inverse; sampled only on the x0 beat.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_re, out_im  out  WIDTH  signed result.
- out_idx  out  2  output index 0/1/2.
- out_last  out  1  high with idx 2.
- out_sat  out  1  this sample's re or im was clipped.

## Operation
Constants (Q10):
- C_HALF = -512; C_SIN = 887.
- Forward W = C_HALF - j·C_SIN. Inverse uses the conjugate.

Intermediate terms:
- t = x1 + x2; d = x1 - x2, per component.
- Accumulator width is WIDTH+13 bits, signed.

Forward accumulators:
- y0 = (x0 + t) << 10.
- y1_re = (x0_re << 10) + C_HALF·t_re + C_SIN·d_im.
- y1_im = (x0_im << 10) + C_HALF·t_im - C_SIN·d_re.
- y2_re = (x0_re << 10) + C_HALF·t_re - C_SIN·d_im.
- y2_im = (x0_im << 10) + C_HALF·t_im + C_SIN·d_re.

Inverse mode:
- y1 and y2 are swapped.

Final scaling of every accumulator:
- Add 2^(9+SHIFT), then arithmetic right-shift by 10+SHIFT (round half up).
- Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- out_sat = 1 if either component clipped.

FSM states COLLECT → CALC → EMIT → COLLECT:
- COLLECT: in_ready = 1. Each in_valid & in_ready beat stores the sample at slot cnt, then cnt increments. The beat with cnt = 0 also latches in_inv. When the beat with cnt = 2 is accepted, go to CALC.
- CALC: one cycle. The six rounded, saturated results and their sat flags are registered; cnt is cleared; go to EMIT.
- EMIT: out_valid = 1. Output comes from the slot at cnt; cnt increments on out_valid & out_ready. When the idx 2 beat is accepted, go to COLLECT.

Backpressure and hold rules:
- While out_ready = 0, out_re, out_im, out_idx, out_last and out_sat hold stable.
- in_valid is ignored outside COLLECT.
- A mode change mid-triple (in_inv toggling on the x1 or x2 beat) has no effect.

## Timing
Reset (asynchronous, any state):
- state = COLLECT, cnt = 0.
- All data registers, out_re, out_im, out_idx, out_last, out_sat and out_valid = 0.
- in_ready = 0 while rst is high; 1 in the first cycle after release.
- A partial triple or an un-emitted result is discarded.

Latency and throughput:
- x2 accepted at edge T: state is CALC in cycle T+1; y0 is valid in cycle T+2.
- Minimum period is 3 in + 1 calc + 3 out = 7 cycles per triple.
- in_ready returns 1 in the cycle after the idx 2 output is accepted.
- No input and output overlap.

## Structure
Package fft_pkg holds:
- COEF_W = 18, COEF_FRAC = 10, C_HALF, C_SIN.
- The FSM state enum (COLLECT, CALC, EMIT).

Sub-module radix3_core:
- Purely combinational.
- Computes x0..x2 + inv → six rounded, saturated outputs + sat flags, parametrised by WIDTH and SHIFT.

The top level holds the FSM, counters, sample slots and output registers.

## Test plan
All cases use WIDTH = 15, SHIFT = 0 unless stated.
- Impulse: x0=(100,0), x1=x2=(0,0), forward → y0=y1=y2=(100,0); out_sat=0; idx 0,1,2; out_last on idx 2.
- DC: x0=x1=x2=(300,0) → y0=(900,0), y1=(0,0), y2=(0,0).
- Twiddle and mode: x0=(0,0), x1=(1000,0), x2=(0,0).
  - Forward → y0=(1000,0), y1=(-500,-866), y2=(-500,866).
  - Inverse (in_inv=1 on the x0 beat only) → y1=(-500,866), y2=(-500,-866).
  - SHIFT=1, forward → y1=(-250,-433).
- Saturation: x0=x1=x2=(16000,0) → y0=(16383,0) with out_sat=1; y1=y2=(0,0) with out_sat=0.
- Backpressure: hold out_ready=0 for 5 cycles at idx 1 → out_valid stays 1 with data stable; in_ready stays 0; no beat is lost or duplicated.
- Reset mid-operation: accept 2 samples, pulse rst for 1 cycle, then send the impulse triple → output exactly as in the impulse case, with all outputs 0 during reset.
